// File: rtl/div_unit_if.sv
// ---------------------------------------------------------------------------
// div_unit_if
// Purpose : Groups the EX-stage <-> divider signals into one bundle.
// Ports (signals):
//   start      request; taken only while the divider is idle
//   alu_op     5-bit ALU op; only DIV/DIVU/REM/REMU start a division
//   operand_a  dividend (rs1)
//   operand_b  divisor  (rs2)
//   flush      abort the current operation
//   stall      hold IF/ID/EX (hazard_t.division)
//   busy       divider is not idle
//   done       one-cycle pulse, result valid
//   result     quotient or remainder
//
// Handshake: start is a request, not a valid/ready pair. The master holds
// start/alu_op/operands while stall=1. A request is accepted on the edge
// where start=1, the op is a division, the divider is idle and flush=0.
// The result is presented with done=1 for exactly one cycle; stall is
// already low in that cycle so EX captures it and advances once.
// ---------------------------------------------------------------------------
interface div_unit_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [4:0]      alu_op;
  logic [XLEN-1:0] operand_a;
  logic [XLEN-1:0] operand_b;
  logic            flush;
  logic            stall;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, alu_op, operand_a, operand_b, flush,
    input  stall, busy, done, result
  );

  modport slave (
    input  start, alu_op, operand_a, operand_b, flush,
    output stall, busy, done, result
  );
endinterface

// File: rtl/div_unit.sv
// ---------------------------------------------------------------------------
// div_unit
// Purpose : Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU.
//           One quotient bit per cycle; divide-by-zero and signed overflow
//           are resolved in IDLE and finish in one cycle.
// Ports:
//   clk          clock
//   rst          synchronous active-high reset
//   bus          div_unit_if.slave (start/alu_op/operands/flush in,
//                stall/busy/done/result out)
//   o_dbg_state  current FSM state (0=IDLE, 1=CALC, 2=DONE)
// Optional feature:
//   DIV_EARLY_OUT_EN  when defined, |dividend| < |divisor| (divisor != 0)
//                     finishes in one cycle (quotient 0, remainder a).
// ---------------------------------------------------------------------------
module div_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic         clk,
  input  logic         rst,
  div_unit_if.slave    bus,
  output logic [1:0]   o_dbg_state
);

  localparam logic [4:0] ALU_DIV  = 5'h10;
  localparam logic [4:0] ALU_DIVU = 5'h11;
  localparam logic [4:0] ALU_REM  = 5'h12;
  localparam logic [4:0] ALU_REMU = 5'h13;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [XLEN-1:0]  r_rem;
  logic [XLEN-1:0]  r_dvd;    // dividend shifts out, quotient shifts in
  logic [XLEN-1:0]  r_dsr;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_is_rem;
  logic             r_done;
  logic [XLEN-1:0]  r_result;

  // ---- request decode ----------------------------------------------------
  logic            w_is_div, w_signed, w_is_rem;
  logic [XLEN-1:0] w_abs_a, w_abs_b;
  logic            w_div0, w_ovf, w_early, w_special, w_accept;
  logic [XLEN-1:0] w_spec_q, w_spec_r, w_spec_res;

  assign w_is_div = (bus.alu_op == ALU_DIV) || (bus.alu_op == ALU_DIVU) ||
                    (bus.alu_op == ALU_REM) || (bus.alu_op == ALU_REMU);
  assign w_signed = (bus.alu_op == ALU_DIV) || (bus.alu_op == ALU_REM);
  assign w_is_rem = (bus.alu_op == ALU_REM) || (bus.alu_op == ALU_REMU);

  assign w_abs_a = (w_signed && bus.operand_a[XLEN-1]) ? -bus.operand_a : bus.operand_a;
  assign w_abs_b = (w_signed && bus.operand_b[XLEN-1]) ? -bus.operand_b : bus.operand_b;

  assign w_div0 = (bus.operand_b == '0);
  assign w_ovf  = w_signed && (bus.operand_a == MIN_NEG) && (bus.operand_b == '1);

`ifdef DIV_EARLY_OUT_EN
  assign w_early = !w_div0 && (w_abs_a < w_abs_b);
`else
  assign w_early = 1'b0;
`endif

  assign w_special = w_div0 || w_ovf || w_early;

  // Early-out shares the divide-by-zero remainder (a, sign intact) and
  // yields a zero quotient.
  assign w_spec_q   = w_div0 ? '1 : (w_ovf ? MIN_NEG : '0);
  assign w_spec_r   = w_ovf ? '0 : bus.operand_a;
  assign w_spec_res = w_is_rem ? w_spec_r : w_spec_q;

  // flush wins over a simultaneous start.
  assign w_accept = (r_state == S_IDLE) && bus.start && w_is_div && !bus.flush;

  // ---- one restoring step ------------------------------------------------
  // The shifted partial remainder is kept one bit wider: with a divisor of
  // 2^(XLEN-1) or more the remainder's MSB can be set before the shift.
  logic [XLEN:0]   w_rem_sh;
  logic            w_ge;
  logic [XLEN-1:0] w_rem_nx, w_quo_nx, w_rem_fin, w_quo_fin, w_calc_res;

  assign w_rem_sh   = {r_rem, r_dvd[XLEN-1]};
  assign w_ge       = (w_rem_sh >= {1'b0, r_dsr});
  // When w_ge the true difference is < 2^XLEN, so dropping the top bit is exact.
  assign w_rem_nx   = w_ge ? (w_rem_sh[XLEN-1:0] - r_dsr) : w_rem_sh[XLEN-1:0];
  assign w_quo_nx   = {r_dvd[XLEN-2:0], w_ge};
  assign w_quo_fin  = r_neg_q ? -w_quo_nx : w_quo_nx;
  assign w_rem_fin  = r_neg_r ? -w_rem_nx : w_rem_nx;
  assign w_calc_res = r_is_rem ? w_rem_fin : w_quo_fin;

  // ---- FSM ---------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_rem    <= '0;
      r_dvd    <= '0;
      r_dsr    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_is_rem <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_neg_q  <= w_signed && (bus.operand_a[XLEN-1] ^ bus.operand_b[XLEN-1]);
            r_neg_r  <= w_signed && bus.operand_a[XLEN-1];
            r_is_rem <= w_is_rem;
            if (w_special) begin
              r_result <= w_spec_res;
              r_done   <= 1'b1;
              r_state  <= S_DONE;
            end else begin
              r_dvd   <= w_abs_a;
              r_dsr   <= w_abs_b;
              r_rem   <= '0;
              r_cnt   <= '0;
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (bus.flush) begin
            r_state <= S_IDLE;
          end else begin
            r_rem <= w_rem_nx;
            r_dvd <= w_quo_nx;
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == CNT_W'(XLEN-1)) begin
              r_result <= w_calc_res;
              r_done   <= 1'b1;
              r_state  <= S_DONE;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.stall   = ((r_state == S_IDLE) && bus.start && w_is_div) || (r_state == S_CALC);
  assign bus.busy    = (r_state != S_IDLE);
  assign bus.done    = r_done;
  assign bus.result  = r_result;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;
  localparam int XLEN = 32;
  localparam logic [4:0] ALU_DIV  = 5'h10;
  localparam logic [4:0] ALU_DIVU = 5'h11;
  localparam logic [4:0] ALU_REM  = 5'h12;
  localparam logic [4:0] ALU_REMU = 5'h13;
  localparam logic [4:0] ALU_ADD  = 5'h00;
`ifdef DIV_EARLY_OUT_EN
  localparam int EO_LAT = 1;
`else
  localparam int EO_LAT = 33;
`endif

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;
  int         cyc;
  int         start_cyc;
  int         n_checks;
  int         n_errors;
  logic [XLEN-1:0] last_res;

  logic [XLEN-1:0] exp_q[$];
  int              lat_q[$];
  string           name_q[$];

  div_unit_if #(.XLEN(XLEN)) dif ();

  div_unit #(.XLEN(XLEN)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (dif),
    .o_dbg_state (dbg_state)
  );

  // ---- clock / reset -----------------------------------------------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---- check helpers -----------------------------------------------------
  task automatic chk(input string nm, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", nm, act, exp);
    end
  endtask

  // ---- monitor / scoreboard ----------------------------------------------
  always @(negedge clk) begin
    if (!rst && dif.done) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_done got=%h exp=no_done", dif.result);
      end else begin
        automatic logic [XLEN-1:0] e = exp_q.pop_front();
        automatic int              l = lat_q.pop_front();
        automatic string           n = name_q.pop_front();
        chk(n, dif.result, e);
        chk_int({n, "_latency"}, cyc - start_cyc, l);
      end
    end
  end

  // ---- driver ------------------------------------------------------------
  task automatic run_op(input string nm, input logic [4:0] op,
                        input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input logic [XLEN-1:0] exp, input int lat);
    int  n_stall;
    bit  seen;
    @(negedge clk);
    dif.start     = 1'b1;
    dif.alu_op    = op;
    dif.operand_a = a;
    dif.operand_b = b;
    exp_q.push_back(exp);
    lat_q.push_back(lat);
    name_q.push_back(nm);
    start_cyc = cyc;
    last_res  = exp;
    n_stall   = 0;
    seen      = 1'b0;
    #1;
    if (dif.stall) n_stall++;
    @(negedge clk);
    dif.start = 1'b0;
    // operand changes after acceptance must not disturb the division
    dif.operand_a = $urandom;
    dif.operand_b = $urandom_range(1, 1000);
    for (int i = 0; i < 60; i++) begin
      #1;
      if (dif.done) begin
        seen = 1'b1;
        break;
      end
      if (dif.stall) n_stall++;
      @(negedge clk);
    end
    if (!seen) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_timeout got=no_done exp=done", nm);
    end
    chk_int({nm, "_stall_cycles"}, n_stall, lat);
    @(negedge clk);
  endtask

  // ---- stimulus ----------------------------------------------------------
  initial begin
    n_checks = 0;
    n_errors = 0;
    start_cyc = 0;
    last_res = '0;
    rst = 1'b1;
    dif.start = 1'b0;
    dif.alu_op = ALU_ADD;
    dif.operand_a = '0;
    dif.operand_b = '0;
    dif.flush = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_done", {31'd0, dif.done}, 32'd0);
    chk("reset_busy", {31'd0, dif.busy}, 32'd0);
    chk("reset_stall", {31'd0, dif.stall}, 32'd0);
    chk("reset_result", dif.result, 32'd0);
    chk("reset_state", {30'd0, dbg_state}, 32'd0);

    run_op("divu_100_7",  ALU_DIVU, 32'd100, 32'd7, 32'd14, 33);
    run_op("remu_100_7",  ALU_REMU, 32'd100, 32'd7, 32'd2,  33);
    run_op("div_m100_7",  ALU_DIV,  32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 33);
    run_op("rem_m100_7",  ALU_REM,  32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 33);
    run_op("div_m7_m2",   ALU_DIV,  32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3, 33);
    run_op("rem_m7_m2",   ALU_REM,  32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 33);
    run_op("div_7_m2",    ALU_DIV,  32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
    run_op("rem_7_m2",    ALU_REM,  32'd7, 32'hFFFF_FFFE, 32'd1, 33);
    run_op("divu_big",    ALU_DIVU, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 33);
    run_op("remu_big",    ALU_REMU, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 33);
    run_op("div_by0",     ALU_DIV,  32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    run_op("remu_by0",    ALU_REMU, 32'd5, 32'd0, 32'd5, 1);
    run_op("div_ovf",     ALU_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("rem_ovf",     ALU_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);

    // non-division op: ignored, no stall
    @(negedge clk);
    dif.start = 1'b1;
    dif.alu_op = ALU_ADD;
    dif.operand_a = 32'd9;
    dif.operand_b = 32'd3;
    #1;
    chk("nondiv_stall", {31'd0, dif.stall}, 32'd0);
    @(negedge clk);
    dif.start = 1'b0;
    #1;
    chk("nondiv_busy", {31'd0, dif.busy}, 32'd0);

    // flush together with start in IDLE: not accepted
    @(negedge clk);
    dif.start = 1'b1;
    dif.flush = 1'b1;
    dif.alu_op = ALU_DIVU;
    dif.operand_a = 32'd50;
    dif.operand_b = 32'd5;
    @(negedge clk);
    dif.start = 1'b0;
    dif.flush = 1'b0;
    #1;
    chk("flush_start_busy", {31'd0, dif.busy}, 32'd0);

    // flush mid-calculation
    @(negedge clk);
    dif.start = 1'b1;
    dif.alu_op = ALU_DIVU;
    dif.operand_a = 32'd1000;
    dif.operand_b = 32'd3;
    @(negedge clk);
    dif.start = 1'b0;
    repeat (9) @(negedge clk);
    #1;
    chk("pre_flush_state", {30'd0, dbg_state}, 32'd1);
    dif.flush = 1'b1;
    @(negedge clk);
    dif.flush = 1'b0;
    #1;
    chk("flush_busy", {31'd0, dif.busy}, 32'd0);
    chk("flush_state", {30'd0, dbg_state}, 32'd0);
    chk("flush_result_held", dif.result, last_res);
    repeat (2) @(negedge clk);
    chk("flush_no_done_result", dif.result, last_res);
    run_op("divu_1000_3", ALU_DIVU, 32'd1000, 32'd3, 32'd333, 33);

    run_op("divu_3_10", ALU_DIVU, 32'd3, 32'd10, 32'd0, EO_LAT);
    run_op("remu_3_10", ALU_REMU, 32'd3, 32'd10, 32'd3, EO_LAT);

    // reset mid-operation: abandoned, no done, result cleared
    @(negedge clk);
    dif.start = 1'b1;
    dif.alu_op = ALU_DIVU;
    dif.operand_a = 32'd77;
    dif.operand_b = 32'd4;
    @(negedge clk);
    dif.start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midreset_busy", {31'd0, dif.busy}, 32'd0);
    chk("midreset_result", dif.result, 32'd0);
    repeat (40) @(negedge clk);

    chk_int("pending_expected", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // global time bound
  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
